a2d_sched: RTL
==============

Name: a2d_sched

Overview:
- Round-robin conversion scheduler for the shared SPI A2D converter.
- Sequences left load cell, right load cell and battery conversions through one SPI master.
- Holds the latest 12-bit result per channel for steer_en (lft_ld, rght_ld) and the piezo/battery logic (batt).
- A round is triggered by nxt, which is driven from the inertial interface's valid pulse, so load readings stay paced with balance updates.

Parameters:
- LFT_CH, 3'd0, A2D channel for left load cell.
- RGHT_CH, 3'd4, A2D channel for right load cell.
- BATT_CH, 3'd5, A2D channel for battery.
- SETTLE_CYC, 4, idle clocks between command and read transactions (min 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- nxt  input  1  one-cycle pulse: start a conversion round.
- done  input  1  SPI master one-cycle pulse: transaction complete.
- rd_data  input  16  SPI master receive word; valid in the cycle done is high.
- wrt  output  1  one-cycle pulse: start an SPI transaction.
- cmd  output  16  SPI transmit word; held stable from the wrt cycle until done.
- lft_ld  output  12  latest left load result.
- rght_ld  output  12  latest right load result.
- batt  output  12  latest battery result.
- busy  output  1  high while a round is in progress.
- upd  output  1  one-cycle pulse after the last result of a round is stored.
- drop  output  1  one-cycle pulse when nxt arrives while busy.

Behaviour:
- Reset (rst high at a clk edge, synchronous):
  - State returns to IDLE.
  - lft_ld = rght_ld = 12'h000; batt = 12'hFFF, so no false low-battery indication.
  - cmd = 16'h0000; wrt, busy, upd, drop = 0.
  - Reset mid-transaction abandons the round. A done pulse that arrives later is ignored in IDLE.
- States: IDLE, SEND_CMD, WAIT_CMD, SETTLE, SEND_RD, WAIT_RD, STORE.
- Channel index ci ∈ {0,1,2} maps to LFT_CH, RGHT_CH, BATT_CH. ci = 0 on round start.
- Transitions:
  - IDLE: nxt → SEND_CMD, ci = 0, busy = 1.
  - SEND_CMD: wrt = 1 for one cycle; cmd = {2'b00, ch[2:0], 11'h000} → WAIT_CMD.
  - WAIT_CMD: done → SETTLE; the SETTLE_CYC counter loads.
  - SETTLE: counter decrements; at 0 → SEND_RD.
  - SEND_RD: wrt = 1 for one cycle; cmd is held at the same value → WAIT_RD.
  - WAIT_RD: done → STORE; the result register selected by ci latches rd_data[11:0]. rd_data[15:12] is discarded.
  - STORE: if ci == 2, go to IDLE, pulse upd, clear busy; otherwise ci++ and go to SEND_CMD.
- Latency: with an SPI transaction of T clocks (wrt to done), one channel takes 2T + SETTLE_CYC + 3 clocks.
- Result registers change only in the cycle after their WAIT_RD done. The others hold.
- wrt is never asserted while waiting on done (at most one outstanding transaction).
- nxt while busy: ignored, drop pulses the same cycle, the round continues undisturbed.
- nxt coincident with upd (STORE→IDLE cycle): ignored, drop pulses. The next round needs a fresh nxt.
- done outside WAIT_CMD/WAIT_RD: ignored.

Optional Feature:
- Macro: A2D_BATT_DECIM_EN.
- Defined:
  - A 3-bit round counter (reset 0) increments on each completed round.
  - The battery slot runs only when the counter == 0, i.e. on rounds 1, 9, 17, ….
  - Other rounds end after the right channel. upd still pulses at round end; batt holds.
- Undefined: every round converts all three channels; no round counter exists.

Test Plan:
- Reset, then SPI model returns 16'hF123/16'h0456/16'h0789; pulse nxt → cmd sequence 16'h0000,16'h0000,16'h2000,16'h2000,16'h2800,16'h2800. Then lft_ld = 12'h123, rght_ld = 12'h456, batt = 12'h789, one upd pulse, busy low.
- SPI done latency 32 clocks, SETTLE_CYC = 4 → gap from WAIT_CMD done to the second wrt is exactly 5 clocks. Round length from nxt to upd = 3·(2·32 + 4 + 3) + 1 clocks.
- nxt pulsed during WAIT_RD of the right channel → drop = 1 for that cycle, results unchanged, exactly one upd.
- rst asserted during WAIT_CMD of the battery channel, late done injected → lft_ld = rght_ld = 0, batt = 12'hFFF, no wrt, busy = 0.
- Spurious done in IDLE and in SETTLE → no state change, no register update.
- A2D_BATT_DECIM_EN defined, 9 nxt rounds → battery cmd 16'h2800 appears on rounds 1 and 9 only. batt updates only then; upd pulses 9 times.

Source files
------------

// File: rtl/a2d_sched_if.sv
// SPI master handshake between the conversion scheduler and the shared A2D
// SPI master: transmit word with start strobe, receive word with done strobe.
interface a2d_sched_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, cmd, input done, rd_data);
  modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/a2d_sched.sv
// Round-robin left-load / right-load / battery conversion scheduler for one SPI A2D.
// Optional macro A2D_BATT_DECIM_EN: battery converted only on every 8th round.
module a2d_sched #(
  parameter logic [2:0] LFT_CH     = 3'd0,
  parameter logic [2:0] RGHT_CH    = 3'd4,
  parameter logic [2:0] BATT_CH    = 3'd5,
  parameter int         SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nxt,
  a2d_sched_if.master       bus,
  output logic [11:0]       lft_ld,
  output logic [11:0]       rght_ld,
  output logic [11:0]       batt,
  output logic              busy,
  output logic              upd,
  output logic              drop
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, WAIT_CMD, SETTLE, SEND_RD, WAIT_RD, STORE
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       ci;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      cmd_q;
  logic             start;
  logic             last;
  logic             unused_rd_hi;

  function automatic logic [2:0] ch_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return LFT_CH;
      2'd1:    return RGHT_CH;
      default: return BATT_CH;
    endcase
  endfunction

  // A round may not start in the upd cycle: that nxt is dropped like any other.
  assign start = (state == IDLE) && nxt && !upd;

`ifdef A2D_BATT_DECIM_EN
  logic [2:0] rnd_cnt;
  assign last = (ci == 2'd2) || ((ci == 2'd1) && (rnd_cnt != 3'd0));

  always_ff @(posedge clk) begin
    if (rst)
      rnd_cnt <= 3'd0;
    else if (state == STORE && last)
      rnd_cnt <= rnd_cnt + 3'd1;
  end
`else
  assign last = (ci == 2'd2);
`endif

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SEND_CMD;
      SEND_CMD: state_nxt = WAIT_CMD;
      WAIT_CMD: if (bus.done) state_nxt = SETTLE;
      SETTLE:   if (cnt == '0) state_nxt = SEND_RD;
      SEND_RD:  state_nxt = WAIT_RD;
      WAIT_RD:  if (bus.done) state_nxt = STORE;
      STORE:    state_nxt = last ? IDLE : SEND_CMD;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ci      <= 2'd0;
      cnt     <= '0;
      cmd_q   <= 16'h0000;
      lft_ld  <= 12'h000;
      rght_ld <= 12'h000;
      batt    <= 12'hFFF;
      upd     <= 1'b0;
    end else begin
      state <= state_nxt;
      upd   <= (state == STORE) && last;

      if (start) begin
        ci    <= 2'd0;
        cmd_q <= {2'b00, ch_of(2'd0), 11'h000};
      end

      if (state == WAIT_CMD && bus.done)
        cnt <= CNT_LOAD;
      else if (state == SETTLE && cnt != '0)
        cnt <= cnt - 1'b1;

      if (state == WAIT_RD && bus.done) begin
        case (ci)
          2'd0:    lft_ld  <= bus.rd_data[11:0];
          2'd1:    rght_ld <= bus.rd_data[11:0];
          default: batt    <= bus.rd_data[11:0];
        endcase
      end

      if (state == STORE && !last) begin
        ci    <= ci + 2'd1;
        cmd_q <= {2'b00, ch_of(ci + 2'd1), 11'h000};
      end
    end
  end

  assign bus.wrt      = (state == SEND_CMD) || (state == SEND_RD);
  assign bus.cmd      = cmd_q;
  assign busy         = (state != IDLE);
  assign drop         = nxt && (busy || upd);
  assign unused_rd_hi = ^bus.rd_data[15:12];

endmodule
